// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory wait stalls.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             ifid_use_rs1_i,
  input  logic             ifid_use_rs2_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [2:0]       idex_mem_read_i,
  input  logic             branch_taken_i,
  input  logic             imem_busy_wait_i,
  input  logic             dmem_busy_wait_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             idex_stall_o,
  output logic             exmem_stall_o,
  output logic             memwb_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, BUBBLE, FLUSH} state_e;

  localparam logic [1:0] BubbleLoad = 2'(LOAD_USE_BUBBLES - 1);

  state_e     state_q, state_d;
  logic [1:0] bubbleCnt_q, bubbleCnt_d;

  logic loadUse;
  logic pcStall, ifidStall, idexStall, exmemStall, memwbStall;
  logic ifidFlush, idexFlush;

  assign loadUse = (idex_mem_read_i != 3'd0) && (idex_rd_i != 5'd0) &&
                   ((ifid_use_rs1_i && (ifid_rs1_i == idex_rd_i)) ||
                    (ifid_use_rs2_i && (ifid_rs2_i == idex_rd_i)));

  // Priority chain: data wait, branch redirect, flush tail, bubble, fetch wait.
  always_comb begin
    state_d     = state_q;
    bubbleCnt_d = bubbleCnt_q;
    pcStall     = 1'b0;
    ifidStall   = 1'b0;
    idexStall   = 1'b0;
    exmemStall  = 1'b0;
    memwbStall  = 1'b0;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    if (dmem_busy_wait_i) begin
      pcStall    = 1'b1;
      ifidStall  = 1'b1;
      idexStall  = 1'b1;
      exmemStall = 1'b1;
      memwbStall = 1'b1;
    end else if (branch_taken_i) begin
      ifidFlush   = 1'b1;
      idexFlush   = 1'b1;
      state_d     = FLUSH;
      bubbleCnt_d = 2'd0;
    end else if (state_q == FLUSH) begin
      ifidFlush = 1'b1;
      state_d   = RUN;
    end else if ((state_q == BUBBLE) || loadUse) begin
      pcStall   = 1'b1;
      ifidStall = 1'b1;
      idexFlush = 1'b1;
      if (state_q == BUBBLE) begin
        bubbleCnt_d = bubbleCnt_q - 2'd1;
        if (bubbleCnt_q == 2'd1) begin
          state_d = RUN;
        end
      end else if (LOAD_USE_BUBBLES > 1) begin
        state_d     = BUBBLE;
        bubbleCnt_d = BubbleLoad;
      end
    end else if (imem_busy_wait_i) begin
      pcStall   = 1'b1;
      ifidFlush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      bubbleCnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      bubbleCnt_q <= bubbleCnt_d;
    end
  end

  // Outputs are masked while reset is held so nothing leaks from live inputs.
  assign pc_stall_o    = rst_n & pcStall;
  assign ifid_stall_o  = rst_n & ifidStall;
  assign idex_stall_o  = rst_n & idexStall;
  assign exmem_stall_o = rst_n & exmemStall;
  assign memwb_stall_o = rst_n & memwbStall;
  assign ifid_flush_o  = rst_n & ifidFlush;
  assign idex_flush_o  = rst_n & idexFlush;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (pcStall && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + 1'b1;
      end
      if ((ifidFlush || idexFlush) && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (1 and 3 bubbles) share
// stimulus; a spec-level model predicts each cycle's outputs into a queue.
module tb_pipeline_hazard_ctrl;

   localparam int NB_A = 1;
   localparam int NB_B = 3;
   localparam int W_A  = 16;
   localparam int W_B  = 4;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       use1, use2;
      logic [2:0] memRead;
      logic       branch, imem, dmem, rstN;
   } stim_t;

   typedef struct {
      logic [6:0]     outA, outB;
      logic [W_A-1:0] stA, flA;
      logic [W_B-1:0] stB, flB;
   } exp_t;

   logic clk = 1'b0;
   logic rstN;
   logic [4:0] rs1, rs2, rd;
   logic use1, use2, branch, imem, dmem;
   logic [2:0] memRead;

   logic pcA, ifA, idA, exA, mwA, iffA, idfA;
   logic pcB, ifB, idB, exB, mwB, iffB, idfB;
   logic [W_A-1:0] stCntA, flCntA;
   logic [W_B-1:0] stCntB, flCntB;

   exp_t expQ[$];
   int checkCnt = 0;
   int passCnt  = 0;

   // Model state, in spec terms: bubbles still owed and a pending flush tail.
   int bubblesLeft[2];
   bit flushNext[2];
   int stallCount[2];
   int flushCount[2];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(NB_A), .CNT_W(W_A)) dutA (
      .clk(clk), .rst_n(rstN),
      .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_use_rs1_i(use1), .ifid_use_rs2_i(use2),
      .idex_rd_i(rd), .idex_mem_read_i(memRead), .branch_taken_i(branch),
      .imem_busy_wait_i(imem), .dmem_busy_wait_i(dmem),
      .pc_stall_o(pcA), .ifid_stall_o(ifA), .idex_stall_o(idA), .exmem_stall_o(exA),
      .memwb_stall_o(mwA), .ifid_flush_o(iffA), .idex_flush_o(idfA),
      .stall_cnt_o(stCntA), .flush_cnt_o(flCntA));

   pipeline_hazard_ctrl #(.LOAD_USE_BUBBLES(NB_B), .CNT_W(W_B)) dutB (
      .clk(clk), .rst_n(rstN),
      .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .ifid_use_rs1_i(use1), .ifid_use_rs2_i(use2),
      .idex_rd_i(rd), .idex_mem_read_i(memRead), .branch_taken_i(branch),
      .imem_busy_wait_i(imem), .dmem_busy_wait_i(dmem),
      .pc_stall_o(pcB), .ifid_stall_o(ifB), .idex_stall_o(idB), .exmem_stall_o(exB),
      .memwb_stall_o(mwB), .ifid_flush_o(iffB), .idex_flush_o(idfB),
      .stall_cnt_o(stCntB), .flush_cnt_o(flCntB));

   // Predicts one instance's outputs {pc,ifid,idex,exmem,memwb,ifidFlush,idexFlush}.
   task automatic modelStep(input stim_t s, input int idx, input int nBubbles, input int maxCnt,
                            output logic [6:0] o, output int stOut, output int flOut);
      bit hazard;
      hazard = (s.memRead != 0) && (s.rd != 0) &&
               ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
      o = 7'b0000000;
      if (!s.rstN) begin
         bubblesLeft[idx] = 0;
         flushNext[idx]   = 0;
         stallCount[idx]  = 0;
         flushCount[idx]  = 0;
      end else if (s.dmem) begin
         o = 7'b1111100;
      end else if (s.branch) begin
         o = 7'b0000011;
         flushNext[idx]   = 1;
         bubblesLeft[idx] = 0;
      end else if (flushNext[idx]) begin
         o = 7'b0000010;
         flushNext[idx] = 0;
      end else if (bubblesLeft[idx] > 0) begin
         o = 7'b1100001;
         bubblesLeft[idx]--;
      end else if (hazard) begin
         o = 7'b1100001;
         bubblesLeft[idx] = nBubbles - 1;
      end else if (s.imem) begin
         o = 7'b1000010;
      end
      stOut = stallCount[idx];
      flOut = flushCount[idx];
      if (s.rstN) begin
         if (o[6] && stallCount[idx] < maxCnt) stallCount[idx]++;
         if ((o[1] || o[0]) && flushCount[idx] < maxCnt) flushCount[idx]++;
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      exp_t e;
      int st, fl;
      @(posedge clk);
      #1;
      rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; use1 = s.use1; use2 = s.use2;
      memRead = s.memRead; branch = s.branch; imem = s.imem; dmem = s.dmem; rstN = s.rstN;
      modelStep(s, 0, NB_A, (1 << W_A) - 1, e.outA, st, fl);
`ifdef HAZARD_STATS_EN
      e.stA = W_A'(st); e.flA = W_A'(fl);
`else
      e.stA = '0; e.flA = '0;
`endif
      modelStep(s, 1, NB_B, (1 << W_B) - 1, e.outB, st, fl);
`ifdef HAZARD_STATS_EN
      e.stB = W_B'(st); e.flB = W_B'(fl);
`else
      e.stB = '0; e.flB = '0;
`endif
      expQ.push_back(e);
   endtask

   function automatic stim_t mk(input logic [2:0] mr, input logic [4:0] d, input logic [4:0] r1,
                                input logic u1, input logic br, input logic im, input logic dm,
                                input logic rn);
      stim_t s;
      s.memRead = mr; s.rd = d; s.rs1 = r1; s.use1 = u1; s.rs2 = 5'd0; s.use2 = 1'b0;
      s.branch = br; s.imem = im; s.dmem = dm; s.rstN = rn;
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checkCnt++;
      if (act === expv) passCnt++;
      else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
   endtask

   // Monitor: compares whatever the DUTs present mid-cycle against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("outputsA", {25'd0, pcA, ifA, idA, exA, mwA, iffA, idfA}, {25'd0, e.outA});
            checkOutput("outputsB", {25'd0, pcB, ifB, idB, exB, mwB, iffB, idfB}, {25'd0, e.outB});
            checkOutput("countersA", {stCntA, flCntA}, {e.stA, e.flA});
            checkOutput("countersB", {24'd0, stCntB, flCntB}, {24'd0, e.stB, e.flB});
         end
      end
   end

   initial begin
      stim_t idle, lu, s;
      int waitCycles;
      rstN = 1'b0; rs1 = '0; rs2 = '0; rd = '0; use1 = 0; use2 = 0;
      memRead = '0; branch = 0; imem = 0; dmem = 0;
      for (int i = 0; i < 2; i++) begin
         bubblesLeft[i] = 0; flushNext[i] = 0; stallCount[i] = 0; flushCount[i] = 0;
      end
      idle = mk(3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      lu   = mk(3'b010, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset with live hazard inputs: outputs must stay quiet.
      s = lu; s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
      applyStimulus(idle);

      // Single load-use: one bubble for A, three for B.
      applyStimulus(lu);
      repeat (4) applyStimulus(idle);

      // rd = x0 never stalls.
      s = lu; s.rd = 5'd0; s.rs1 = 5'd0;
      applyStimulus(s);
      applyStimulus(idle);

      // Hazard through rs2 only, and an unused matching rs1.
      s = lu; s.use1 = 1'b0; s.rs2 = 5'd5; s.use2 = 1'b1;
      applyStimulus(s);
      s.use2 = 1'b0;
      applyStimulus(s);
      repeat (3) applyStimulus(idle);

      // Branch coincident with load-use and with imem busy.
      s = lu; s.branch = 1'b1; s.imem = 1'b1;
      applyStimulus(s);
      applyStimulus(idle);
      applyStimulus(idle);

      // Data wait for 4 cycles inside B's bubble sequence.
      applyStimulus(lu);
      s = idle; s.dmem = 1'b1;
      repeat (4) applyStimulus(s);
      repeat (3) applyStimulus(idle);

      // Branch during B's bubble, then branch again from FLUSH.
      applyStimulus(lu);
      s = idle; s.branch = 1'b1;
      applyStimulus(s);
      applyStimulus(s);
      applyStimulus(idle);
      applyStimulus(idle);

      // Reset mid-FLUSH, then mid-bubble.
      applyStimulus(s);
      s = idle; s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(idle);
      applyStimulus(lu);
      s = idle; s.rstN = 1'b0;
      applyStimulus(s);
      applyStimulus(idle);
      applyStimulus(idle);

      // Long fetch wait saturates the narrow counter of instance B.
      s = idle; s.imem = 1'b1;
      repeat (20) applyStimulus(s);
      applyStimulus(idle);

      // Randomized traffic with a small register space to provoke matches.
      for (int n = 0; n < 3000; n++) begin
         s.rs1     = 5'($urandom_range(0, 3));
         s.rs2     = 5'($urandom_range(0, 3));
         s.rd      = 5'($urandom_range(0, 3));
         s.use1    = 1'($urandom_range(0, 1));
         s.use2    = 1'($urandom_range(0, 1));
         s.memRead = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
         s.branch  = ($urandom_range(0, 7) == 0);
         s.imem    = ($urandom_range(0, 3) == 0);
         s.dmem    = ($urandom_range(0, 7) == 0);
         s.rstN    = ($urandom_range(0, 99) != 0);
         applyStimulus(s);
      end
      applyStimulus(idle);

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 5) begin
         @(negedge clk);
         waitCycles++;
      end
      #1;
      if (expQ.size() > 0) begin
         checkCnt++;
         $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
      end
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter LOAD_USE_BUBBLES, default 1 (legal 1..3), giving bubbles inserted per load-use hazard.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving statistics counter width.
REQ-003 The block SHALL have port CLK  input  1  single clock, all state updated on rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports IFID_RS1, IFID_RS2  input  5 each  source register addresses of the instruction in ID.
REQ-006 The block SHALL have ports IFID_USE_RS1, IFID_USE_RS2  input  1 each  ID instruction actually reads RS1/RS2.
REQ-007 The block SHALL have ports IDEX_RD  input  5  and IDEX_MEM_READ  input  3  destination and load type of the instruction in EX (nonzero = load).
REQ-008 The block SHALL have port BRANCH_TAKEN  input  1  redirect resolved in EX this cycle.
REQ-009 The block SHALL have ports IMEM_BUSY_WAIT, DMEM_BUSY_WAIT  input  1 each  memory not ready.
REQ-010 The block SHALL have outputs PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL  output  1 each  hold register contents.
REQ-011 The block SHALL have outputs IFID_FLUSH, IDEX_FLUSH  output  1 each  load NOP into that register.
REQ-012 The block SHALL have outputs STALL_CNT, FLUSH_CNT  output  CNT_W each  statistics counters.

Function
REQ-013 The FSM SHALL have states RUN, BUBBLE, FLUSH; outputs SHALL be combinational from state and inputs, state registered.
REQ-014 Load-use hazard SHALL be IDEX_MEM_READ!=0 and IDEX_RD!=0 and IDEX_RD matches a used RS1/RS2; rd=x0 is never a hazard.
REQ-015 Priority per cycle SHALL be: DMEM_BUSY_WAIT > BRANCH_TAKEN > FLUSH state > load-use/BUBBLE > IMEM_BUSY_WAIT.
REQ-016 DMEM_BUSY_WAIT=1 SHALL assert all five STALL outputs, no FLUSH, and hold state and bubble counter unchanged.
REQ-017 BRANCH_TAKEN (no DMEM busy) SHALL assert IFID_FLUSH and IDEX_FLUSH, PC_STALL=0 even if IMEM busy, and go to FLUSH.
REQ-018 FLUSH state SHALL assert IFID_FLUSH only for exactly one cycle, then return to RUN; a new BRANCH_TAKEN there restarts FLUSH.
REQ-019 Load-use in RUN SHALL assert PC_STALL, IFID_STALL, IDEX_FLUSH; if LOAD_USE_BUBBLES>1 go to BUBBLE with counter LOAD_USE_BUBBLES-1.
REQ-020 BUBBLE SHALL repeat REQ-019 outputs each cycle, decrementing counter, returning to RUN when it reaches 0; total bubbles = LOAD_USE_BUBBLES.
REQ-021 Branch in load-use cycle or BUBBLE SHALL win: bubble sequence abandoned, REQ-017 applies.
REQ-022 IMEM_BUSY_WAIT alone SHALL assert PC_STALL and IFID_FLUSH; later stages advance.
REQ-023 With no event in RUN, all STALL and FLUSH outputs SHALL be 0.

Reset
REQ-024 RESET low SHALL immediately force state RUN, bubble counter 0, STALL_CNT=FLUSH_CNT=0, all STALL/FLUSH outputs 0, regardless of CLK.
REQ-025 Reset mid-BUBBLE or mid-FLUSH SHALL discard the sequence; first edge after release evaluates from RUN.

Configuration
REQ-026 Macro HAZARD_STATS_EN defined: STALL_CNT SHALL increment each cycle PC_STALL=1, FLUSH_CNT each cycle any FLUSH=1, both saturating at all-ones.
REQ-027 Macro HAZARD_STATS_EN undefined: counters SHALL be absent, STALL_CNT and FLUSH_CNT tied 0, control behaviour identical.

Verification
REQ-028 IDEX_MEM_READ=3'b010, IDEX_RD=5, IFID_RS1=5, USE_RS1=1 -> one cycle PC_STALL=IFID_STALL=IDEX_FLUSH=1, then RUN.
REQ-029 Same with IDEX_RD=0 -> no stall; with LOAD_USE_BUBBLES=3 and RD=5 -> exactly 3 bubble cycles.
REQ-030 BRANCH_TAKEN=1 coincident with load-use -> IFID_FLUSH=IDEX_FLUSH=1, PC_STALL=0, next cycle IFID_FLUSH only.
REQ-031 DMEM_BUSY_WAIT=1 for 4 cycles during BUBBLE -> all STALL=1, bubble count resumes unchanged after release.
REQ-032 RESET low mid-FLUSH -> outputs 0 immediately; with HAZARD_STATS_EN, 2^CNT_W+5 stall cycles -> STALL_CNT all-ones.
